mcb_ref_sched: RTL and testbench
================================

MCB_REF_SCHED -- requirements
Module: mcb_ref_sched

Interface
REQ-001 Parameter REF_INTV, default 1560: mcb_clk cycles per refresh interval (tREFI); legal range 2 to 2^CNT_W.
REQ-002 Parameter CNT_W, default 12: width of the interval counter.
REQ-003 Parameter MAX_PEND, default 8: maximum postponed refreshes; legal range 1 to 2^PEND_W-1.
REQ-004 Parameter ALERT_TH, default 4: pending level at which alert asserts; legal range 1 to MAX_PEND.
REQ-005 Parameter PEND_W, default 4: width of the pending counter.
REQ-006 Parameter MAX_PULLIN, default 2: maximum refreshes issued ahead of schedule; used only when MCB_REF_PULLIN_EN is defined.
REQ-007 mcb_clk  input  1  single clock; all state changes on its rising edge.
REQ-008 mcb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 mcb_sclr_n  input  1  synchronous clear, active-low.
REQ-010 i_ready  input  1  initialisation complete; level signal.
REQ-011 c_ready  input  1  command controller idle; can accept a refresh this cycle.
REQ-012 c_ref  input  1  one-cycle pulse; an auto-refresh command was issued.
REQ-013 r_ref_req  output  1  refresh requested.
REQ-014 r_ref_alert  output  1  pending count >= ALERT_TH; the command controller stops accepting new bursts.
REQ-015 r_ref_urgent  output  1  pending count == MAX_PEND.
REQ-016 r_ref_pend  output  PEND_W  current pending count.
REQ-017 r_ref_ovf  output  1  sticky error: an interval tick occurred while pending count was already MAX_PEND.

Function
REQ-018 FSM states: IDLE and RUN; IDLE->RUN when i_ready=1; RUN->IDLE when i_ready=0.
REQ-019 On every entry to IDLE: interval counter, pending count and pull-in credit cleared; r_ref_ovf retained.
REQ-020 In RUN, the interval counter loads REF_INTV-1 on entry, decrements each cycle, and at 0 generates a one-cycle tick and reloads REF_INTV-1, so ticks occur every REF_INTV cycles; the first tick occurs REF_INTV cycles after entering RUN.
REQ-021 On a tick without c_ref, with credit == 0: pending increments, saturating at MAX_PEND.
REQ-022 On a tick without c_ref, with credit > 0: credit decrements and pending is unchanged.
REQ-023 On c_ref without a tick, with pending > 0: pending decrements.
REQ-024 On a tick and c_ref in the same cycle: pending and credit are both unchanged.
REQ-025 On a tick with pending == MAX_PEND and no c_ref: r_ref_ovf sets to 1 and pending stays at MAX_PEND.
REQ-026 r_ref_req, r_ref_alert and r_ref_urgent are registered, with one cycle of latency from a pending change.
REQ-027 r_ref_req = (pending != 0).
REQ-028 r_ref_pend equals the pending register, with no added latency.
REQ-029 c_ref in IDLE, or c_ref with pending == 0 while pull-in is disabled, is ignored and changes no state.

Reset
REQ-030 While mcb_rst_n=0: state IDLE and all registers 0, including every output and r_ref_ovf.
REQ-031 mcb_sclr_n=0 at a rising edge has the same effect as reset, synchronously; mcb_sclr_n takes priority over all other inputs.
REQ-032 Reset or clear asserted mid-interval discards the partial interval; the full REF_INTV period restarts after the next IDLE->RUN transition.

Configuration
REQ-033 Macro MCB_REF_PULLIN_EN defined: in RUN, when pending == 0, credit < MAX_PULLIN and c_ready=1, r_ref_req also asserts (registered); each c_ref accepted with pending == 0 increments credit, saturating at MAX_PULLIN.
REQ-034 Macro MCB_REF_PULLIN_EN undefined: credit logic is absent, credit reads as constant 0, and r_ref_req = (pending != 0) only.

Verification
REQ-035 REF_INTV=16, reset released, i_ready=1 at cycle 0, no c_ref -> first tick at cycle 16; r_ref_pend=1 and r_ref_req=1 by cycle 17.
REQ-036 REF_INTV=16, ALERT_TH=4, MAX_PEND=8, no c_ref for 8 intervals -> r_ref_alert rises after the 4th tick, r_ref_urgent after the 8th; the 9th tick sets r_ref_ovf=1 and r_ref_pend stays 8.
REQ-037 pending=3; c_ref pulsed on the exact tick cycle -> r_ref_pend remains 3; a c_ref on the next cycle -> 2.
REQ-038 pending=5, then i_ready deasserted for 1 cycle -> pending=0, r_ref_req=0, r_ref_ovf unchanged; the next tick occurs 16 cycles after i_ready returns.
REQ-039 MCB_REF_PULLIN_EN, MAX_PULLIN=2, pending=0, c_ready=1 -> r_ref_req=1; 3 c_ref pulses -> credit=2 (saturated); the next 2 ticks leave r_ref_pend=0 and the 3rd tick gives 1.
REQ-040 mcb_sclr_n low for 1 cycle with pending=6 and r_ref_ovf=1 -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/mcb_ref_sched_if.sv
// Refresh scheduler <-> command controller handshake bundle.
// The controller side uses the master modport and the scheduler uses the slave modport.
interface mcb_ref_sched_if #(
  parameter int PEND_W = 4
);
  logic              c_ready;
  logic              c_ref;
  logic              r_ref_req;
  logic              r_ref_alert;
  logic              r_ref_urgent;
  logic [PEND_W-1:0] r_ref_pend;
  logic              r_ref_ovf;

  modport master (
    output c_ready, c_ref,
    input  r_ref_req, r_ref_alert, r_ref_urgent, r_ref_pend, r_ref_ovf
  );

  modport slave (
    input  c_ready, c_ref,
    output r_ref_req, r_ref_alert, r_ref_urgent, r_ref_pend, r_ref_ovf
  );
endinterface

// File: rtl/mcb_ref_sched.sv
// DRAM auto-refresh scheduler: tREFI interval timer, postponed-refresh accounting, alert/urgent/overflow flags.
// Optional refresh pull-in (issuing refreshes ahead of schedule) is enabled by defining MCB_REF_PULLIN_EN.
module mcb_ref_sched #(
  parameter int REF_INTV   = 1560,
  parameter int CNT_W      = 12,
  parameter int MAX_PEND   = 8,
  parameter int ALERT_TH   = 4,
  parameter int PEND_W     = 4,
  parameter int MAX_PULLIN = 2
) (
  input  logic mcb_clk,
  input  logic mcb_rst_n,
  input  logic mcb_sclr_n,
  input  logic i_ready,
  mcb_ref_sched_if.slave ref_if
);

  localparam int CR_W = (MAX_PULLIN < 1) ? 1 : $clog2(MAX_PULLIN + 1);

  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(REF_INTV - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_ALERT = PEND_W'(ALERT_TH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pend;
  logic [CR_W-1:0]   credit;
  logic              tick;
  logic              pull;
  logic              req;
  logic              alert;
  logic              urgent;
  logic              ovf;

  assign tick = (state == RUN) && (cnt == '0);

`ifdef MCB_REF_PULLIN_EN
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(MAX_PULLIN);

  // Credit only grows while pend == 0 and pend only grows while credit == 0,
  // so at most one of them is ever non-zero.
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      credit <= '0;
    end else if (!mcb_sclr_n) begin
      credit <= '0;
    end else if (state != RUN || !i_ready) begin
      credit <= '0;
    end else if (tick && !ref_if.c_ref && credit != '0) begin
      credit <= credit - 1'b1;
    end else if (!tick && ref_if.c_ref && pend == '0 && credit < CR_MAX) begin
      credit <= credit + 1'b1;
    end
  end

  assign pull = (state == RUN) && (pend == '0) && (credit < CR_MAX) && ref_if.c_ready;
`else
  assign credit = '0;
  assign pull   = 1'b0;
`endif

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= '0;
      ovf    <= 1'b0;
      req    <= 1'b0;
      alert  <= 1'b0;
      urgent <= 1'b0;
    end else if (!mcb_sclr_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= '0;
      ovf    <= 1'b0;
      req    <= 1'b0;
      alert  <= 1'b0;
      urgent <= 1'b0;
    end else begin
      // Flags follow the pending register one cycle later.
      req    <= (pend != '0) || pull;
      alert  <= (pend >= PEND_ALERT);
      urgent <= (pend == PEND_MAX);
      case (state)
        IDLE: begin
          cnt  <= '0;
          pend <= '0;
          if (i_ready) begin
            state <= RUN;
            cnt   <= RELOAD;
          end
        end
        RUN: begin
          if (!i_ready) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
          end else begin
            cnt <= tick ? RELOAD : cnt - 1'b1;
            if (tick && !ref_if.c_ref) begin
              if (credit == '0) begin
                if (pend == PEND_MAX) begin
                  ovf <= 1'b1;
                end else begin
                  pend <= pend + 1'b1;
                end
              end
            end else if (!tick && ref_if.c_ref && pend != '0) begin
              pend <= pend - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ref_if.r_ref_req    = req;
  assign ref_if.r_ref_alert  = alert;
  assign ref_if.r_ref_urgent = urgent;
  assign ref_if.r_ref_pend   = pend;
  assign ref_if.r_ref_ovf    = ovf;

endmodule

// File: tb/tb_mcb_ref_sched.sv
// Directed self-checking bench for mcb_ref_sched with REF_INTV=16, MAX_PEND=8, ALERT_TH=4.
// Edge index cyc counts rising edges from the IDLE->RUN edge (cyc 0); checks sample #1 after an edge.
module tb_mcb_ref_sched;

  logic clk;
  logic rst_n;
  logic sclr_n;
  logic i_ready;
  int   n_chk;
  int   n_err;
  int   cyc;

  mcb_ref_sched_if #(.PEND_W(4)) bus ();

  mcb_ref_sched #(
    .REF_INTV   (16),
    .CNT_W      (12),
    .MAX_PEND   (8),
    .ALERT_TH   (4),
    .PEND_W     (4),
    .MAX_PULLIN (2)
  ) dut (
    .mcb_clk    (clk),
    .mcb_rst_n  (rst_n),
    .mcb_sclr_n (sclr_n),
    .i_ready    (i_ready),
    .ref_if     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, int'(bus.r_ref_req), 0);
    check({tag, "_alert"}, int'(bus.r_ref_alert), 0);
    check({tag, "_urgent"}, int'(bus.r_ref_urgent), 0);
    check({tag, "_pend"}, int'(bus.r_ref_pend), 0);
    check({tag, "_ovf"}, int'(bus.r_ref_ovf), 0);
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    cyc         = -100;
    rst_n       = 1'b0;
    sclr_n      = 1'b1;
    i_ready     = 1'b0;
    bus.c_ready = 1'b0;
    bus.c_ref   = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // c_ref while IDLE is ignored
    bus.c_ref = 1'b1;
    step();
    bus.c_ref = 1'b0;
    step();
    check("idle_cref_pend", int'(bus.r_ref_pend), 0);
    check("idle_cref_req", int'(bus.r_ref_req), 0);

    // First interval and saturation
    i_ready = 1'b1;
    cyc = -1;
    run_to(15);  check("pre_tick1_pend", int'(bus.r_ref_pend), 0);
    run_to(16);  check("tick1_pend", int'(bus.r_ref_pend), 1);
                 check("tick1_req_lat", int'(bus.r_ref_req), 0);
    run_to(17);  check("tick1_req", int'(bus.r_ref_req), 1);
    run_to(64);  check("tick4_pend", int'(bus.r_ref_pend), 4);
                 check("tick4_alert_lat", int'(bus.r_ref_alert), 0);
    run_to(65);  check("tick4_alert", int'(bus.r_ref_alert), 1);
    run_to(128); check("tick8_pend", int'(bus.r_ref_pend), 8);
                 check("tick8_urgent_lat", int'(bus.r_ref_urgent), 0);
    run_to(129); check("tick8_urgent", int'(bus.r_ref_urgent), 1);
    run_to(143); check("pre_ovf", int'(bus.r_ref_ovf), 0);
    run_to(144); check("tick9_ovf", int'(bus.r_ref_ovf), 1);
                 check("tick9_pend", int'(bus.r_ref_pend), 8);

    // Drain to 5, then drop i_ready for one cycle
    bus.c_ref = 1'b1;
    run_to(147);
    bus.c_ref = 1'b0;
    check("drain_pend5", int'(bus.r_ref_pend), 5);
    i_ready = 1'b0;
    run_to(148); check("idle_pend", int'(bus.r_ref_pend), 0);
    i_ready = 1'b1;
    run_to(149); check("idle_req", int'(bus.r_ref_req), 0);
                 check("idle_alert", int'(bus.r_ref_alert), 0);
                 check("idle_ovf_kept", int'(bus.r_ref_ovf), 1);
    run_to(164); check("rerun_pre_tick", int'(bus.r_ref_pend), 0);
    run_to(165); check("rerun_tick", int'(bus.r_ref_pend), 1);
    run_to(245); check("pend6", int'(bus.r_ref_pend), 6);
                 check("pend6_alert", int'(bus.r_ref_alert), 1);

    // Synchronous clear
    sclr_n = 1'b0;
    run_to(246);
    sclr_n = 1'b1;
    check_all_zero("sclr");

    // Tick and c_ref in the same cycle
    cyc = -1;
    run_to(47);  check("clr_pend2", int'(bus.r_ref_pend), 2);
    run_to(48);  check("clr_pend3", int'(bus.r_ref_pend), 3);
    run_to(63);
    bus.c_ref = 1'b1;
    run_to(64);  check("tick_cref_pend", int'(bus.r_ref_pend), 3);
    run_to(65);  check("cref_after_tick", int'(bus.r_ref_pend), 2);
    run_to(67);
    bus.c_ref = 1'b0;
    check("drain_pend0", int'(bus.r_ref_pend), 0);

`ifdef MCB_REF_PULLIN_EN
    bus.c_ready = 1'b1;
    run_to(68);  check("pullin_req", int'(bus.r_ref_req), 1);
    bus.c_ref = 1'b1;
    run_to(71);
    bus.c_ref = 1'b0;
    run_to(72);  check("pullin_sat_req", int'(bus.r_ref_req), 0);
    run_to(96);  check("pullin_tick2_pend", int'(bus.r_ref_pend), 0);
    run_to(112); check("pullin_tick3_pend", int'(bus.r_ref_pend), 1);
`else
    bus.c_ref = 1'b1;
    run_to(68);
    bus.c_ref = 1'b0;
    check("zero_cref_pend", int'(bus.r_ref_pend), 0);
    run_to(79);  check("zero_cref_pre_tick", int'(bus.r_ref_pend), 0);
    run_to(80);  check("zero_cref_tick", int'(bus.r_ref_pend), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
